int_accept_seq: RTL

- CPU-side interrupt acceptance sequencer, between the interrupt controller's request output and the core's pipeline and data bus.
- At an instruction boundary it qualifies the pending request against SR.IMASK and acknowledges it.
- It then runs the exception entry sequence on the shared data bus: push SR, push return PC, fetch the vector from VBR+4*VEC.
- Finally it hands the new PC, R15 and IMASK back to the core.

---
 rtl/int_accept_seq_pkg.sv | 41 ++++
 rtl/int_accept_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_accept_seq_pkg.sv
// -----------------------------------------------------------------------------
// int_accept_seq_pkg
// Shared types and constants for the CPU-side interrupt acceptance sequencer.
//   IntSeqState_t : sequencer state encoding
//   IntReq_t      : request bundle from the interrupt controller
//   IntAck_t      : acknowledge bundle back to the interrupt controller
//   INT_NMI_VEC   : vector number that ignores the IMASK compare
//   INT_SEQ_SP_DEC: stack pointer decrement per push
// -----------------------------------------------------------------------------
package int_accept_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACKS = 3'd1,
        PSR  = 3'd2,
        PPC  = 3'd3,
        VFET = 3'd4,
        DONE = 3'd5
    } IntSeqState_t;

    typedef struct packed {
        logic       req;
        logic [3:0] lvl;
        logic [7:0] vec;
    } IntReq_t;

    typedef struct packed {
        logic       ack;
        logic [3:0] lvl;
    } IntAck_t;

    localparam logic [7:0]  INT_NMI_VEC    = 8'd11;
    localparam logic [31:0] INT_SEQ_SP_DEC = 32'd4;

    // Vector table entry address: VBR + 4*VEC, wrapping modulo 2^32.
    function automatic logic [31:0] vec_addr(input logic [31:0] vbr,
                                             input logic [7:0]  vec);
        return vbr + {22'b0, vec, 2'b00};
    endfunction

endpackage

// File: rtl/int_accept_seq.sv
// -----------------------------------------------------------------------------
// int_accept_seq
// Interrupt acceptance sequencer. At an instruction boundary it qualifies the
// pending request against SR.IMASK, acknowledges it, pushes SR and the return
// PC on the stack, fetches the handler address from VBR+4*VEC and hands the
// new PC / R15 / IMASK back to the core.
//
// Ports
//   CLK, RST (sync, active-high), CE_R (global clock enable)
//   INT_REQ/INT_LVL/INT_VEC : request from controller
//   ACK/ACK_LVL             : acknowledge pulse and current IMASK to controller
//   BOUNDARY, SR_IN, RET_PC, R15_IN, VBR : core context
//   STALL                   : holds the core pipeline while sequencing
//   BUS_*                   : shared data bus master port
//   NEW_VALID/NEW_PC/NEW_R15/NEW_IMASK : context load pulse to the core
// -----------------------------------------------------------------------------
module int_accept_seq
    import int_accept_seq_pkg::*;
#(
    parameter logic [7:0]  NMI_VEC = INT_NMI_VEC,
    parameter logic [31:0] SP_DEC  = INT_SEQ_SP_DEC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        INT_REQ,
    input  logic [3:0]  INT_LVL,
    input  logic [7:0]  INT_VEC,
    output logic        ACK,
    output logic [3:0]  ACK_LVL,
    input  logic        BOUNDARY,
    input  logic [31:0] SR_IN,
    input  logic [31:0] RET_PC,
    input  logic [31:0] R15_IN,
    input  logic [31:0] VBR,
    output logic        STALL,
    output logic [31:0] BUS_A,
    output logic [31:0] BUS_DO,
    input  logic [31:0] BUS_DI,
    output logic        BUS_WE,
    output logic        BUS_REQ,
    input  logic        BUS_BUSY,
    output logic        NEW_VALID,
    output logic [31:0] NEW_PC,
    output logic [31:0] NEW_R15,
    output logic [3:0]  NEW_IMASK
);

    // Two pushes below the entry stack pointer.
    localparam logic [31:0] SP_DEC2 = SP_DEC << 1;

    IntReq_t int_req;
    IntAck_t int_ack;

    assign int_req = '{req: INT_REQ, lvl: INT_LVL, vec: INT_VEC};

    IntSeqState_t state_q, state_d;

    // Context captured at accept time; later input changes are ignored.
    logic [3:0]  lvl_q, lvl_d;
    logic [7:0]  vec_q, vec_d;
    logic [31:0] sr_q, sr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] r15_q, r15_d;

    // Registered outputs.
    logic        ack_q, ack_d;
    logic        stall_q, stall_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_a_q, bus_a_d;
    logic [31:0] bus_do_q, bus_do_d;
    logic        new_valid_q, new_valid_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [31:0] new_r15_q, new_r15_d;
    logic [3:0]  new_imask_q, new_imask_d;

    logic accept;
    logic is_nmi_q;

    // NMI bypasses the mask; otherwise strict unsigned greater-than, so
    // level 0 can never win.
    assign accept = CE_R & BOUNDARY & int_req.req &
                    ((int_req.vec == NMI_VEC) | (int_req.lvl > SR_IN[7:4]));

    assign is_nmi_q = (vec_q == NMI_VEC);

    always_comb begin
        state_d     = state_q;
        lvl_d       = lvl_q;
        vec_d       = vec_q;
        sr_d        = sr_q;
        pc_d        = pc_q;
        r15_d       = r15_q;
        ack_d       = ack_q;
        stall_d     = stall_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_a_d     = bus_a_q;
        bus_do_d    = bus_do_q;
        new_valid_d = new_valid_q;
        new_pc_d    = new_pc_q;
        new_r15_d   = new_r15_q;
        new_imask_d = new_imask_q;

        // With CE_R low everything holds, so pulses simply stretch.
        if (CE_R) begin
            case (state_q)
                IDLE: begin
                    ack_d       = 1'b0;
                    new_valid_d = 1'b0;
                    if (accept) begin
                        lvl_d   = int_req.lvl;
                        vec_d   = int_req.vec;
                        sr_d    = SR_IN;
                        pc_d    = RET_PC;
                        r15_d   = R15_IN;
                        ack_d   = 1'b1;
                        stall_d = 1'b1;
                        state_d = ACKS;
                    end
                end
                ACKS: begin
                    ack_d     = 1'b0;
                    bus_req_d = 1'b1;
                    bus_we_d  = 1'b1;
                    bus_a_d   = r15_q - SP_DEC;
                    bus_do_d  = sr_q;
                    state_d   = PSR;
                end
                PSR: begin
                    // Outputs hold while the slave signals wait.
                    if (!BUS_BUSY) begin
                        bus_a_d  = r15_q - SP_DEC2;
                        bus_do_d = pc_q;
                        state_d  = PPC;
                    end
                end
                PPC: begin
                    if (!BUS_BUSY) begin
                        bus_we_d = 1'b0;
                        bus_a_d  = vec_addr(VBR, vec_q);
                        state_d  = VFET;
                    end
                end
                VFET: begin
                    if (!BUS_BUSY) begin
                        new_pc_d    = BUS_DI;
                        new_r15_d   = r15_q - SP_DEC2;
                        new_imask_d = is_nmi_q ? 4'hF : lvl_q;
                        new_valid_d = 1'b1;
                        stall_d     = 1'b0;
                        bus_req_d   = 1'b0;
                        state_d     = DONE;
                    end
                end
                DONE: begin
                    new_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            lvl_q       <= '0;
            vec_q       <= '0;
            sr_q        <= '0;
            pc_q        <= '0;
            r15_q       <= '0;
            ack_q       <= 1'b0;
            stall_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_a_q     <= '0;
            bus_do_q    <= '0;
            new_valid_q <= 1'b0;
            new_pc_q    <= '0;
            new_r15_q   <= '0;
            new_imask_q <= '0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            vec_q       <= vec_d;
            sr_q        <= sr_d;
            pc_q        <= pc_d;
            r15_q       <= r15_d;
            ack_q       <= ack_d;
            stall_q     <= stall_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_a_q     <= bus_a_d;
            bus_do_q    <= bus_do_d;
            new_valid_q <= new_valid_d;
            new_pc_q    <= new_pc_d;
            new_r15_q   <= new_r15_d;
            new_imask_q <= new_imask_d;
        end
    end

    // Current mask is fed back combinationally so the controller can
    // re-arbitrate without waiting for a register stage.
    assign int_ack = '{ack: ack_q, lvl: SR_IN[7:4]};

    assign ACK       = int_ack.ack;
    assign ACK_LVL   = int_ack.lvl;
    assign STALL     = stall_q;
    assign BUS_A     = bus_a_q;
    assign BUS_DO    = bus_do_q;
    assign BUS_WE    = bus_we_q;
    assign BUS_REQ   = bus_req_q;
    assign NEW_VALID = new_valid_q;
    assign NEW_PC    = new_pc_q;
    assign NEW_R15   = new_r15_q;
    assign NEW_IMASK = new_imask_q;

endmodule
